seg_scan_display: RTL and testbench
===================================

// Module: seg_scan_display
// PURPOSE
//  Parametrised multiplexed 7-segment controller for the vending-machine front panel.
//  Captures NUM_FIELDS unsigned values on a load strobe and converts each one
//  sequentially to two BCD digits (shift-add-3).
//  Commits all fields atomically to the display registers, then time-multiplexes
//  2*NUM_FIELDS digits with a built-in scan prescaler.
//  Replaces per-value fixed lookup decoders and the hard-wired scan sequence.
// PARAMETERS
//  NUM_FIELDS  4       number of 2-digit fields; digits = 2*NUM_FIELDS (1..4)
//  VAL_W       7       width of each field value (4..7); displayable range 0..99
//  SCAN_DIV    100000  clk cycles per digit slot (>=2)
//  BLANK_LZ    1       1: blank the tens digit when it is 0 (no effect on over-range)
// PORTS
//  clk       in   1                 system clock
//  rst       in   1                 asynchronous, active-low reset
//  values    in   NUM_FIELDS*VAL_W  field f = values[f*VAL_W +: VAL_W]
//  load      in   1                 capture request, sampled only in IDLE
//  field_en  in   NUM_FIELDS        per-field digit enable
//  seg_en    in   1                 global display enable
//  busy      out  1                 conversion in progress
//  done      out  1                 one-cycle pulse: new values committed
//  DIG       out  2*NUM_FIELDS      one-hot digit select, active-high; bit 2f = tens, bit 2f+1 = units of field f
//  SEG       out  8                 segments {dp,g,f,e,d,c,b,a}, active-high; dp always 0
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; busy=0, done=0, DIG=0, SEG=0.
//    Prescaler=0, slot=0; all display and shadow registers=0.
//  FSM: IDLE -> CONV -> WRITE -> (CONV for next field | IDLE).
//  IDLE:
//    load=1 snapshots values; field index=0; go CONV.
//  CONV (one field):
//    Runs exactly VAL_W cycles of double-dabble on the snapshot field.
//  WRITE (1 cycle):
//    value<=99 stores tens/units BCD in the shadow registers.
//    value>99 sets the shadow over-range flag.
//    Not last field: index++, go CONV. Last field: go IDLE.
//  Load accepted at cycle 0:
//    busy=1 in cycles 1..NUM_FIELDS*(VAL_W+1).
//    In cycle NUM_FIELDS*(VAL_W+1)+1, busy=0 and done=1; the shadow is copied
//    to the display registers in that same cycle.
//  Handshake:
//    load while busy is ignored, with no queueing.
//    load in the done cycle is accepted, so a new conversion starts.
//  Display registers change only on commit, never partially.
//  Scan:
//    Prescaler counts 0..SCAN_DIV-1.
//    At terminal count, slot wraps 2*NUM_FIELDS-1 -> 0.
//  DIG/SEG are registered, with 1-cycle latency from the slot, seg_en and field_en.
//    Slot s normally gives DIG = 1<<s and SEG = the digit code.
//    seg_en=0 gives DIG=0 and SEG=0.
//    field_en[s/2]=0 gives DIG=0 and SEG=0.
//    In both cases the prescaler and slot keep running.
//  Codes 0-9: 3F 06 5B 4F 66 6D 7D 27 7F 67.
//  Over-range field: both digits show 8'h40 ("--").
//  BLANK_LZ=1 and tens==0 on a non-over-range field:
//    tens slot keeps DIG asserted with SEG=8'h00.
//  Reset mid-conversion: abort immediately; shadow discarded; no done; display=0.
// TESTING (NUM_FIELDS=2, VAL_W=7, SCAN_DIV=4, BLANK_LZ=1)
//  1. Reset, then seg_en=1, field_en=2'b11 -> DIG steps 0001,0010,0100,1000 every 4 clks.
//     Tens slots give SEG=00 and units slots give SEG=3F.
//  2. values={99,5}, load pulse -> busy high 16 clks, done pulse on clk 17.
//     Slot0 gives 00, slot1 6D, slot2 67, slot3 67.
//  3. values={100,127}, load -> all four slots SEG=40.
//     Reload {10,0}: slots give 00,3F,06,3F.
//  4. load at clks 5 and 12 of a conversion -> ignored, single done.
//     load on the done cycle -> busy=1 next clk, second done 17 clks later.
//  5. field_en=2'b01 -> slots 2,3 give DIG=0, SEG=0.
//     seg_en=0 for 6 clks then 1 -> resumes in the slot implied by the free-running count.
//  6. rst low at clk 8 of a conversion -> busy=0 at once, no done, slots show blank/3F.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment controller: snapshots NUM_FIELDS values, converts each to BCD
// (VAL_W+1 clks per field), commits atomically, scans digits; loads while busy are dropped.
module seg_scan_display #(
  parameter int NUM_FIELDS = 4,
  parameter int VAL_W      = 7,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FIELDS*VAL_W-1:0] values,
  input  logic                        load,
  input  logic [NUM_FIELDS-1:0]       field_en,
  input  logic                        seg_en,
  output logic                        busy,
  output logic                        done,
  output logic [2*NUM_FIELDS-1:0]     DIG,
  output logic [7:0]                  SEG
);

  localparam int DIGITS = 2 * NUM_FIELDS;
  localparam int SLOT_W = $clog2(DIGITS);
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int FI_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W  = $clog2(VAL_W);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE} state_e;

  state_e                           state_q, state_d;
  logic [NUM_FIELDS-1:0][VAL_W-1:0] snap_q;
  logic [FI_W-1:0]                  idx_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [VAL_W-1:0]                 sh_q;
  logic [7:0]                       bcd_q, bcd_nx;
  logic [3:0]                       adj_t, adj_u;
  logic                             last_field, conv_end, ovr_now, done_q;

  logic [NUM_FIELDS-1:0][3:0]       sh_tens_q, sh_tens_d, sh_units_q, sh_units_d;
  logic [NUM_FIELDS-1:0]            sh_ovr_q, sh_ovr_d;
  logic [NUM_FIELDS-1:0][3:0]       disp_tens_q, disp_units_q;
  logic [NUM_FIELDS-1:0]            disp_ovr_q;

  logic [PRE_W-1:0]                 presc_q;
  logic [SLOT_W-1:0]                slot_q;
  logic [FI_W-1:0]                  fsel;
  logic [3:0]                       digit;
  logic [DIGITS-1:0]                dig_q, dig_d;
  logic [7:0]                       seg_q, seg_d;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h27;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h67;
      default: return 8'h00;
    endcase
  endfunction

  assign last_field = (idx_q == FI_W'(NUM_FIELDS - 1));
  assign conv_end   = (cnt_q == CNT_W'(VAL_W - 1));
  assign ovr_now    = (32'(snap_q[idx_q]) > 32'd99);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_CONV;
      S_CONV:  if (conv_end) state_d = S_WRITE;
      S_WRITE: state_d = last_field ? S_IDLE : S_CONV;
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to any nibble >= 5, then shift in the next MSB.
  // Tens overflow is irrelevant because values above 99 are flagged separately.
  always_comb begin
    adj_t  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    adj_u  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_nx = 8'({adj_t, adj_u, sh_q[VAL_W-1]});
  end

  always_comb begin
    sh_tens_d  = sh_tens_q;
    sh_units_d = sh_units_q;
    sh_ovr_d   = sh_ovr_q;
    if (state_q == S_WRITE) begin
      sh_ovr_d[idx_q] = ovr_now;
      if (!ovr_now) begin
        sh_tens_d[idx_q]  = bcd_q[7:4];
        sh_units_d[idx_q] = bcd_q[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      sh_q         <= '0;
      bcd_q        <= '0;
      done_q       <= 1'b0;
      sh_tens_q    <= '0;
      sh_units_q   <= '0;
      sh_ovr_q     <= '0;
      disp_tens_q  <= '0;
      disp_units_q <= '0;
      disp_ovr_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      sh_tens_q  <= sh_tens_d;
      sh_units_q <= sh_units_d;
      sh_ovr_q   <= sh_ovr_d;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            snap_q <= values;
            idx_q  <= '0;
            sh_q   <= values[VAL_W-1:0];
            bcd_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_CONV: begin
          cnt_q <= cnt_q + 1'b1;
          bcd_q <= bcd_nx;
          sh_q  <= sh_q << 1;
        end
        S_WRITE: begin
          if (last_field) begin
            // Commit takes the merged shadow so the last field lands with the rest.
            disp_tens_q  <= sh_tens_d;
            disp_units_q <= sh_units_d;
            disp_ovr_q   <= sh_ovr_d;
            done_q       <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            sh_q  <= snap_q[idx_q + 1'b1];
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsel  = FI_W'(slot_q >> 1);
    digit = slot_q[0] ? disp_units_q[fsel] : disp_tens_q[fsel];
    dig_d = '0;
    seg_d = '0;
    if (seg_en && field_en[fsel]) begin
      dig_d = DIGITS'(1) << slot_q;
      if (disp_ovr_q[fsel])
        seg_d = 8'h40;
      else if (!slot_q[0] && (BLANK_LZ != 0) && (digit == 4'd0))
        seg_d = 8'h00;
      else
        seg_d = seg_code(digit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      slot_q  <= '0;
      dig_q   <= '0;
      seg_q   <= '0;
    end else begin
      if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        slot_q  <= (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign DIG  = dig_q;
  assign SEG  = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed steps plus random loads, checked every cycle
// against a cycle-count/arithmetic reference model.
module tb_seg_scan_display;

  localparam int NF  = 2;
  localparam int VW  = 7;
  localparam int DIV = 4;
  localparam int ND  = 2 * NF;
  localparam int CONV_CYC = NF * (VW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [NF*VW-1:0] values;
  logic            load;
  logic [NF-1:0]   field_en;
  logic            seg_en;
  logic            busy, done;
  logic [ND-1:0]   DIG;
  logic [7:0]      SEG;

  int tests = 0;
  int fails = 0;

  seg_scan_display #(
    .NUM_FIELDS(NF), .VAL_W(VW), .SCAN_DIV(DIV), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .values(values), .load(load),
    .field_en(field_en), .seg_en(seg_en),
    .busy(busy), .done(done), .DIG(DIG), .SEG(SEG)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] code7(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h27;
      8: return 8'h7F;  9: return 8'h67;
      default: return 8'h00;
    endcase
  endfunction

  // Reference: slot follows the free-running edge count, conversion is a countdown.
  int          m_edge = 0;
  int          m_rem = 0;
  int          m_pend [NF];
  int          m_disp [NF];
  int          m_slot, m_f, m_v;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [ND-1:0] exp_dig = '0;
  logic [7:0]  exp_seg = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edge = 0; m_rem = 0;
      for (int i = 0; i < NF; i++) begin m_pend[i] = 0; m_disp[i] = 0; end
      exp_busy = 1'b0; exp_done = 1'b0; exp_dig = '0; exp_seg = '0;
    end else begin
      m_slot  = (m_edge / DIV) % ND;
      m_f     = m_slot / 2;
      m_v     = m_disp[m_f];
      exp_dig = '0;
      exp_seg = '0;
      if (seg_en && field_en[m_f]) begin
        exp_dig = ND'(1 << m_slot);
        if (m_v > 99)            exp_seg = 8'h40;
        else if (m_slot % 2 == 0) exp_seg = (m_v / 10 == 0) ? 8'h00 : code7(m_v / 10);
        else                      exp_seg = code7(m_v % 10);
      end
      exp_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp   = m_pend;
          exp_done = 1'b1;
        end
      end else if (load) begin
        for (int i = 0; i < NF; i++) m_pend[i] = int'(values[i*VW +: VW]);
        m_rem = CONV_CYC;
      end
      exp_busy = (m_rem > 0);
      m_edge++;
    end
  end

  task automatic check_all(input string tag);
    tests++;
    assert (busy === exp_busy) else begin
      fails++; $error("FAIL %s busy got %b expected %b", tag, busy, exp_busy);
    end
    tests++;
    assert (done === exp_done) else begin
      fails++; $error("FAIL %s done got %b expected %b", tag, done, exp_done);
    end
    tests++;
    assert (DIG === exp_dig) else begin
      fails++; $error("FAIL %s DIG got %b expected %b", tag, DIG, exp_dig);
    end
    tests++;
    assert (SEG === exp_seg) else begin
      fails++; $error("FAIL %s SEG got %h expected %h", tag, SEG, exp_seg);
    end
  endtask

  task automatic tick(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_all(tag);
    end
  endtask

  task automatic load_pulse(input int v1, input int v0, input string tag);
    values = {VW'(v1), VW'(v0)};
    load   = 1'b1;
    tick(1, tag);
    load   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; values = '0; field_en = '0; seg_en = 1'b0;
    #2 rst = 1'b0;
    #1 check_all("reset");
    tick(1, "reset_hold");
    rst = 1'b1;

    // Idle scan of the all-zero display.
    seg_en = 1'b1; field_en = 2'b11;
    tick(20, "scan_idle");

    load_pulse(99, 5, "conv_99_5");
    tick(35, "conv_99_5");

    load_pulse(100, 127, "ovr");
    tick(35, "ovr");
    load_pulse(10, 0, "reload_10_0");
    tick(35, "reload_10_0");

    // Loads mid-conversion are dropped; a load in the done cycle starts a new run.
    load_pulse(42, 7, "busy_load");
    tick(4, "busy_load");
    load_pulse(1, 2, "busy_ignore5");
    tick(6, "busy_load");
    load_pulse(3, 4, "busy_ignore12");
    tick(4, "busy_load");
    load_pulse(88, 63, "done_cycle_load");
    tick(35, "second_conv");

    field_en = 2'b01;
    tick(20, "field_mask");
    field_en = 2'b11;
    seg_en = 1'b0;
    tick(6, "seg_off");
    seg_en = 1'b1;
    tick(20, "seg_resume");

    for (int it = 0; it < 25; it++) begin
      field_en = NF'($urandom);
      seg_en   = ($urandom_range(0, 3) != 0);
      load_pulse(int'($urandom_range(0, 127)), int'($urandom_range(0, 110)), "rand");
      tick(int'($urandom_range(0, 24)), "rand");
    end
    field_en = 2'b11; seg_en = 1'b1;
    tick(25, "rand_drain");

    // Reset mid-conversion: abort, nothing committed, display back to zero.
    load_pulse(55, 66, "rst_mid_load");
    tick(7, "rst_mid_conv");
    rst = 1'b0;
    #1 check_all("rst_mid_async");
    tick(1, "rst_mid_hold");
    rst = 1'b1;
    tick(30, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
